// File: rtl/right_shift_pkg.sv
// Shared definitions for the multi-cycle right shifter: mode codes, FSM states, default widths.
// Rotate support is compiled in only when RIGHT_SHIFT_ROTATE_EN is defined.
package right_shift_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_AMT_W = 4;

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/right_shift_unit_shift_step.sv
// Combinational one-bit right shift with fill select; returns the bit shifted out.
// Rotate fill exists only when RIGHT_SHIFT_ROTATE_EN is defined; otherwise mode 10 fills with 0.
module shift_step
  import right_shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next_data_c,
  output logic             shifted_out_c
);

  logic fill;

  always_comb begin
    fill = 1'b0;
    if (mode == MODE_ASR) begin
      fill = data[WIDTH-1];
    end
`ifdef RIGHT_SHIFT_ROTATE_EN
    else if (mode == MODE_ROR) begin
      fill = data[0];
    end
`endif
    next_data_c   = {fill, data[WIDTH-1:1]};
    shifted_out_c = data[0];
  end

endmodule

// File: rtl/right_shift_unit.sv
// Sequential right shifter (one bit per clock) with start/busy/done handshake and carry out.
// Optional rotate mode enabled by RIGHT_SHIFT_ROTATE_EN.
module right_shift_unit
  import right_shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned AMT_W = DEF_AMT_W
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] inputVal,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ShiftedVal,
  output logic             carry_out
);

  state_t           state, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [AMT_W-1:0] cnt, cnt_next;
  logic [1:0]       mode_reg, mode_next;
  logic             carry_reg, carry_next;
  logic [WIDTH-1:0] result_next;
  logic             carry_out_next;
  logic [WIDTH-1:0] step_data;
  logic             step_bit;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data          (data_reg),
    .mode          (mode_reg),
    .next_data_c   (step_data),
    .shifted_out_c (step_bit)
  );

  // Result/carry are loaded on the edge that enters DONE, so they are valid with done.
  always_comb begin
    state_next     = state;
    data_next      = data_reg;
    cnt_next       = cnt;
    mode_next      = mode_reg;
    carry_next     = carry_reg;
    result_next    = ShiftedVal;
    carry_out_next = carry_out;
    case (state)
      S_IDLE: begin
        if (start) begin
          data_next  = inputVal;
          cnt_next   = amt;
          mode_next  = mode;
          carry_next = 1'b0;
          if (amt == '0) begin
            state_next     = S_DONE;
            result_next    = inputVal;
            carry_out_next = 1'b0;
          end else begin
            state_next = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        data_next  = step_data;
        carry_next = step_bit;
        cnt_next   = cnt - AMT_W'(1);
        if (cnt == AMT_W'(1)) begin
          state_next     = S_DONE;
          result_next    = step_data;
          carry_out_next = step_bit;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= S_IDLE;
      data_reg   <= '0;
      cnt        <= '0;
      mode_reg   <= MODE_LSR;
      carry_reg  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ShiftedVal <= '0;
      carry_out  <= 1'b0;
    end else begin
      state      <= state_next;
      data_reg   <= data_next;
      cnt        <= cnt_next;
      mode_reg   <= mode_next;
      carry_reg  <= carry_next;
      busy       <= (state_next != S_IDLE);
      done       <= (state_next == S_DONE);
      ShiftedVal <= result_next;
      carry_out  <= carry_out_next;
    end
  end

endmodule

// File: tb/tb_right_shift_unit.sv
// Self-checking bench for right_shift_unit: directed cases plus random operations against a
// reference model; rotate expectations follow RIGHT_SHIFT_ROTATE_EN.
module tb_right_shift_unit;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned AMT_W = 4;

  logic             CLK = 1'b0;
  logic             Reset;
  logic             start;
  logic [WIDTH-1:0] inputVal;
  logic [AMT_W-1:0] amt;
  logic [1:0]       mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ShiftedVal;
  logic             carry_out;

  int compared   = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  right_shift_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .start      (start),
    .inputVal   (inputVal),
    .amt        (amt),
    .mode       (mode),
    .busy       (busy),
    .done       (done),
    .ShiftedVal (ShiftedVal),
    .carry_out  (carry_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: whole shift at once; carry is the original bit at position n-1.
  function automatic logic [WIDTH:0] ref_shift(input logic [WIDTH-1:0] v, input int n,
                                               input logic [1:0] m);
    logic [WIDTH-1:0] r;
    logic             c;
    c = (n == 0) ? 1'b0 : v[n-1];
    case (m)
      2'b01: r = WIDTH'($signed(v) >>> n);
`ifdef RIGHT_SHIFT_ROTATE_EN
      2'b10: r = (n == 0) ? v : WIDTH'((v >> n) | (v << (WIDTH - n)));
`endif
      default: r = v >> n;
    endcase
    return {c, r};
  endfunction

  task automatic run_op(input string tag, input logic [WIDTH-1:0] v, input int n,
                        input logic [1:0] m, input logic [WIDTH-1:0] exp_val, input logic exp_c);
    int got;
    int busy_cnt;
    @(negedge CLK);
    start = 1'b1; inputVal = v; amt = AMT_W'(n); mode = m;
    @(negedge CLK);
    start = 1'b0; inputVal = WIDTH'($urandom); amt = AMT_W'($urandom); mode = 2'($urandom);
    check({tag, ":busy_after_start"}, 32'(busy), 1);
    got = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        got = i;
        break;
      end
      @(negedge CLK);
    end
    check({tag, ":latency"}, 32'(got), 32'(n + 1));
    check({tag, ":result"}, 32'(ShiftedVal), 32'(exp_val));
    check({tag, ":carry"}, 32'(carry_out), 32'(exp_c));
    check({tag, ":busy_cycles"}, 32'(busy_cnt), 32'(n + 1));
    @(negedge CLK);
    check({tag, ":done_pulse_end"}, 32'({done, busy}), 0);
    check({tag, ":result_hold"}, 32'(ShiftedVal), 32'(exp_val));
  endtask

  initial begin
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] v;
    int               n;
    logic [1:0]       m;
    int               done_cnt;
    int               done_cyc;
    logic [WIDTH-1:0] done_val;

    Reset = 1'b1; start = 1'b0; inputVal = '0; amt = '0; mode = 2'b00;
    repeat (2) @(negedge CLK);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_result", 32'(ShiftedVal), 0);
    check("reset_carry", 32'(carry_out), 0);
    Reset = 1'b0;

    run_op("lsr_fd_4", 16'h00FD, 4, 2'b00, 16'h000F, 1'b1);
    run_op("asr_8000_3", 16'h8000, 3, 2'b01, 16'hF000, 1'b0);
    run_op("lsr_ffff_15", 16'hFFFF, 15, 2'b00, 16'h0001, 1'b1);
    run_op("zero_amt", 16'h1234, 0, 2'b00, 16'h1234, 1'b0);
`ifdef RIGHT_SHIFT_ROTATE_EN
    run_op("ror_0001_1", 16'h0001, 1, 2'b10, 16'h8000, 1'b1);
`else
    run_op("ror_0001_1", 16'h0001, 1, 2'b10, 16'h0000, 1'b1);
`endif
    run_op("asr_sat", 16'h9234, 15, 2'b01, 16'hFFFF, 1'b0);
    run_op("reserved_mode", 16'hF00F, 4, 2'b11, 16'h0F00, 1'b1);

    // Second start two cycles into the operation must be ignored.
    @(negedge CLK);
    start = 1'b1; inputVal = 16'h00F0; amt = 4'd4; mode = 2'b00;
    done_cnt = 0; done_cyc = 0; done_val = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      start = (i == 2);
      if (i == 2) begin
        inputVal = 16'hFFFF; amt = 4'd1; mode = 2'b00;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = i;
          done_val = ShiftedVal;
        end
      end
    end
    start = 1'b0;
    check("collision_done_count", 32'(done_cnt), 1);
    check("collision_done_cycle", 32'(done_cyc), 5);
    check("collision_result", 32'(done_val), 32'h000F);

    // Reset in the middle of a shift aborts it.
    @(negedge CLK);
    start = 1'b1; inputVal = 16'hAAAA; amt = 4'd8; mode = 2'b00;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    check("midreset_busy", 32'(busy), 0);
    check("midreset_done", 32'(done), 0);
    check("midreset_result", 32'(ShiftedVal), 0);
    check("midreset_carry", 32'(carry_out), 0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (done || busy) done_cnt++;
    end
    check("midreset_no_activity", 32'(done_cnt), 0);
    run_op("after_reset", 16'hAAAA, 8, 2'b00, 16'h00AA, 1'b1);

    for (int k = 0; k < 30; k++) begin
      v = WIDTH'($urandom);
      n = int'($urandom_range(0, (1 << AMT_W) - 1));
      m = 2'($urandom);
      r = ref_shift(v, n, m);
      run_op($sformatf("rand%0d", k), v, n, m, r[WIDTH-1:0], r[WIDTH]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
